// File: rtl/pool1_rm_reader_if.sv
// Signal bundle for the pool1 buffer read sequencer: command, RAM port B and output stream.
// The master modport is the sequencer's view, the slave modport is the environment's view.
interface pool1_rm_reader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 128
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addrb;
  logic [DATA_WIDTH-1:0] ram_doutb;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // Stream: a word transfers in a cycle where m_valid & m_ready; once m_valid rises,
  // m_data/m_last hold until that transfer, and m_valid never drops without one.
  modport master (
    input  start, base_addr, num_words, ram_doutb, m_ready,
    output busy, done, ram_addrb, m_valid, m_data, m_last
  );
  modport slave (
    output start, base_addr, num_words, ram_doutb, m_ready,
    input  busy, done, ram_addrb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/pool1_rm_reader.sv
// Sweeps a contiguous address range of the pool1 buffer (port B, fixed read latency) and
// streams the words out through a small FIFO; reads are credit-limited so none is ever lost.
module pool1_rm_reader #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 128,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pool1_rm_reader_if.master    bus,
  output logic [1:0]           dbg_state
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addrb_q, ram_addrb_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [READ_LATENCY:0] pv_q, pv_d, pl_q, pl_d;
  logic [DATA_WIDTH-1:0] fd_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fd_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fl_q, fl_d;
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  last_seen_q, last_seen_d;

  logic                  issue, issue_last, push, pop, credit_ok, fifo_empty_next;
  logic [PW+1:0]         pipe_cnt, credit_use;

  // Pipe bit 0 lines up with ram_addrb; the top bit lines up with valid ram_doutb.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i <= READ_LATENCY; i++) begin
      pipe_cnt = pipe_cnt + {{(PW+1){1'b0}}, pv_q[i]};
    end
    push = pv_q[READ_LATENCY];
    pop  = (cnt_q != '0) && bus.m_ready;
    // A word popped this cycle frees its slot in time for a read issued now.
    credit_use = pipe_cnt + {1'b0, cnt_q} - {{(PW+1){1'b0}}, pop};
    credit_ok  = credit_use < (PW+2)'(FIFO_DEPTH);
    fifo_empty_next = (cnt_q == '0) || ((cnt_q == (PW+1)'(1)) && pop);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    ram_addrb_d = ram_addrb_q;
    last_seen_d = last_seen_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        last_seen_d = 1'b0;
        if (bus.start) begin
          if (bus.num_words == '0) begin
            state_d = S_DONE;
          end else begin
            // First read goes out with the command so ram_addrb shows base next cycle.
            issue       = 1'b1;
            issue_last  = (bus.num_words == (ADDR_WIDTH+1)'(1));
            ram_addrb_d = bus.base_addr;
            addr_d      = bus.base_addr + ADDR_WIDTH'(1);
            rem_d       = bus.num_words - (ADDR_WIDTH+1)'(1);
            state_d     = issue_last ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue       = 1'b1;
          issue_last  = (rem_q == (ADDR_WIDTH+1)'(1));
          ram_addrb_d = addr_q;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          rem_d       = rem_q - (ADDR_WIDTH+1)'(1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fl_q[rp_q]) last_seen_d = 1'b1;
        if ((pv_q == '0) && fifo_empty_next && (last_seen_q || (pop && fl_q[rp_q]))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pv_d  = {pv_q[READ_LATENCY-1:0], issue};
    pl_d  = {pl_q[READ_LATENCY-1:0], issue_last};
    fd_d  = fd_q;
    fl_d  = fl_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    if (push) begin
      fd_d[wp_q] = bus.ram_doutb;
      fl_d[wp_q] = pl_q[READ_LATENCY];
      wp_d       = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ram_addrb_q <= '0;
      rem_q       <= '0;
      pv_q        <= '0;
      pl_q        <= '0;
      fl_q        <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fd_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ram_addrb_q <= ram_addrb_d;
      rem_q       <= rem_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      fl_q        <= fl_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.ram_addrb = ram_addrb_q;
  assign bus.m_valid   = (cnt_q != '0);
  assign bus.m_data    = fd_q[rp_q];
  assign bus.m_last    = fl_q[rp_q] && (cnt_q != '0);
  assign dbg_state     = state_q;
endmodule

// File: doc/pool1_rm_reader.md
Name: pool1_rm_reader

Overview:
- Read-side sequencer for the pool1 row-major feature buffer, a simple dual-port RAM with 11-bit address, 128-bit words, read latency 2 and read enable tied high.
- On a start command, it sweeps a contiguous address range of the buffer port B.
- It returns the words to the downstream conv2 input stage over a valid/ready stream.
- A small credit-controlled output FIFO absorbs backpressure, so no in-flight read is ever lost.

Parameters:
- ADDR_WIDTH, 11, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 128, RAM word and stream data width.
- READ_LATENCY, 2, cycles from addrb presented to doutb valid; fixed RAM property.
- FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+1 and a power of 2.

Ports:
- clk  in  1  single clock, shared with the RAM.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; sampled with start.
- num_words  in  ADDR_WIDTH+1  word count, 0..2048; sampled with start.
- busy  out  1  high from the cycle after start accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- ram_addrb  out  ADDR_WIDTH  registered read address to RAM port B.
- ram_doutb  in  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after the address.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  stream data (FIFO head).
- m_last  out  1  high with the final word of the sweep.

Behaviour:
- Reset: state IDLE; busy=0, done=0, m_valid=0, m_last=0, ram_addrb=0, m_data=0.
  - FIFO emptied; in-flight pipe valid bits cleared.
  - Reset mid-sweep aborts the sweep: no done pulse, RAM data still returning is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and num_words=0 -> DONE directly; done pulses in the next cycle; no reads, no m_valid.
  - start=1 and num_words>0 -> latch base and count, go to RUN.
  - start is ignored in every other state.
- RUN: a read issues in a cycle when (outstanding + fifo_count) < FIFO_DEPTH.
  - outstanding = valid bits in the READ_LATENCY pipe.
  - On issue: ram_addrb = current address, a valid bit enters the pipe, the address increments modulo 2^ADDR_WIDTH, and the remaining count decrements.
  - Last issue -> DRAIN.
- Pipe: the issue bit emerges exactly READ_LATENCY cycles later and writes ram_doutb into the FIFO that cycle.
  - The credit rule guarantees the FIFO never overflows; overflow is a bench assertion.
- DRAIN: wait until the pipe and FIFO are empty and the last word handshake (m_valid & m_ready & m_last) has occurred -> DONE.
- DONE: done=1 for one cycle -> IDLE; busy drops in the same cycle done asserts.
- Stream:
  - m_valid = FIFO not empty; m_data/m_last come from the FIFO head.
  - Once m_valid=1, m_data and m_last stay stable until m_ready.
  - A word pops on m_valid & m_ready.
  - A FIFO push and pop in the same cycle are both honoured; count unchanged.
- m_last is tagged at issue time on the read with remaining count = 1 and travels through the pipe with the data.
- Latency:
  - start in cycle 0, m_ready held 1 -> ram_addrb=base in cycle 1, first m_valid in cycle 4.
  - Thereafter one word per cycle sustained; total words out = num_words.
- ram_addrb holds its last value when no read issues.

Test Plan:
- Basic sweep: base=0, num_words=8, m_ready=1 -> m_data = RAM[0..7] in cycles 4..11; m_last in cycle 11; done in cycle 12; busy 1..11.
- Backpressure: num_words=16, m_ready toggles 1,0,0,1 repeating -> all 16 words in order, none dropped or duplicated; FIFO count never exceeds 4; reads stall when credits are exhausted.
- Address wrap: base=2046, num_words=4 -> ram_addrb sequence 2046, 2047, 0, 1; data order matches.
- Zero and full length:
  - num_words=0 -> done one cycle after start, m_valid never asserts.
  - num_words=2048, base=5 -> 2048 words; the last read is from address 4.
- Reset mid-sweep: assert rst in cycle 6 of a 32-word sweep -> next cycle all outputs at reset values, no done.
  - A new start then runs a clean 4-word sweep.
- start while busy: pulse start with a different base in cycle 3 of a sweep -> ignored; the original sweep completes unchanged.
